mat_result_writer: RTL
======================

Name: mat_result_writer

Overview:
- Consumer side of the matrix-multiply control strobes.
- Watches the result-ready strobe (wire_out) from the multiply controller and captures the MAC accumulator value on each valid strobe.
- Writes each captured value to the result RAM at sequential addresses, counts results, and signals completion.
- Sits between the MAC datapath/controller and the result memory; the host sees only busy/done/error flags.

Parameters:
- DATA_W, 16, width of the MAC accumulator value and of RAM write data.
- ADDR_W, 6, result RAM address width.
- N_RESULTS, 64, number of results per matrix operation; must be ≤ 2**ADDR_W.
- SKIP_FIRST, 1, when 1 the first strobe after start is discarded, because the accumulator is empty at that point.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; operation request, same signal the controller sees.
- wire_out  in  1  result-ready strobe from the controller; single-cycle or multi-cycle.
- mac_in  in  DATA_W  accumulator value, valid in any cycle where wire_out=1.
- ctrl_done  in  1  controller done level.
- wr_en  out  1  result RAM write enable.
- wr_addr  out  ADDR_W  result RAM write address.
- wr_data  out  DATA_W  result RAM write data.
- result_count  out  ADDR_W+1  results written so far this operation.
- busy  out  1  high in ARMED and COLLECT.
- done  out  1  high in DONE.
- short_err  out  1  sticky; controller finished before N_RESULTS writes.
- overflow  out  1  sticky; strobe received after N_RESULTS writes.

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - state=IDLE.
  - wr_en=0, wr_addr=0, wr_data=0, result_count=0, busy=0, done=0, short_err=0, overflow=0.
  - Any capture pending at reset is dropped; no write occurs in the cycle after reset.
- Strobe edge detect: a "strobe event" is wire_out=1 with prior-cycle wire_out=0. A multi-cycle high counts as one event. The prior-cycle register clears on reset.
- States:
  - IDLE:
    - start=1 → ARMED.
    - On entry to ARMED: result_count, short_err and overflow clear; skip flag loads SKIP_FIRST.
  - ARMED:
    - Strobe event with skip=1: discard it, clear skip, → COLLECT.
    - Strobe event with skip=0: capture it, → COLLECT.
    - ctrl_done=1 before any strobe: short_err=1, → DONE.
  - COLLECT:
    - Each strobe event registers mac_in.
    - Next cycle: wr_en=1 for exactly one cycle, wr_addr=result_count[ADDR_W-1:0], wr_data=captured value.
    - result_count increments in that same cycle.
    - Latency: strobe event cycle T → write in cycle T+1.
    - When result_count reaches N_RESULTS after a write → DONE.
  - DONE:
    - done=1.
    - Strobe events are ignored for writing and set overflow=1.
    - start=0 → IDLE; done deasserts in the IDLE cycle.
- Simultaneous strobe event and ctrl_done in COLLECT: the capture and write complete first.
  - If result_count < N_RESULTS after that write: short_err=1, → DONE.
- ctrl_done in COLLECT with no strobe: if result_count < N_RESULTS, short_err=1, → DONE.
- start dropping in ARMED or COLLECT: abort.
  - Any pending write still completes.
  - → IDLE; done is never asserted.
- Address wrap: wr_addr never exceeds N_RESULTS-1; result_count saturates at N_RESULTS.
- wr_en is never high in two consecutive cycles unless two distinct strobe events occur in consecutive cycles. Edge detection prevents this.
- mac_in is sampled only in strobe-event cycles; mac_in changes at other times have no effect.

Test Plan:
1. Reset for 2 cycles, then idle with wire_out toggling → wr_en stays 0, all outputs 0, state IDLE.
2. SKIP_FIRST=1, start=1, then 65 strobe events spaced 8 cycles apart, mac_in=i*3 on event i → event 0 is dropped; 64 writes at addr 0..63 with data 3..192; each write one cycle after its strobe; done=1 after the 64th; overflow=0.
3. After scenario 2, send one more strobe while start is held → overflow=1, no write; drop start → IDLE next cycle, done=0.
4. SKIP_FIRST=1, start, 11 strobe events (10 captured), then ctrl_done=1 → 10 writes at addr 0..9, short_err=1, done=1.
5. wire_out held high for 5 cycles in COLLECT → exactly one write, result_count increments by 1.
6. Assert reset on the strobe-event cycle mid-COLLECT (result_count=5) → the following cycle has wr_en=0, result_count=0, state IDLE, all flags cleared.

Source files
------------

// File: rtl/mat_result_writer.sv
// Result writer for the matrix-multiply engine: captures the MAC accumulator on each
// result-ready strobe edge and writes it to the result RAM at sequential addresses.
module mat_result_writer #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 6,
  parameter int N_RESULTS  = 64,
  parameter int SKIP_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              wire_out,
  input  logic [DATA_W-1:0] mac_in,
  input  logic              ctrl_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W:0]   result_count,
  output logic              busy,
  output logic              done,
  output logic              short_err,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, ARMED, COLLECT, DONE} state_t;

  localparam logic [ADDR_W:0] N_CNT = (ADDR_W+1)'(N_RESULTS);

  state_t          state, state_next;
  logic            wire_q;
  logic            strobe_ev;
  logic            skip;
  logic            fin_pend;
  logic            end_req;
  logic [ADDR_W:0] cnt_inc;

  logic arm, capture, skip_clr, set_short, set_ovf, fin_set;

  assign strobe_ev = wire_out & ~wire_q;
  assign cnt_inc   = result_count + 1'b1;
  // A ctrl_done pulse that lands on a capture cycle is remembered until the write retires.
  assign end_req   = ctrl_done | fin_pend;
  assign busy      = (state == ARMED) || (state == COLLECT);
  assign done      = (state == DONE);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    arm        = 1'b0;
    capture    = 1'b0;
    skip_clr   = 1'b0;
    set_short  = 1'b0;
    set_ovf    = 1'b0;
    fin_set    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = ARMED;
          arm        = 1'b1;
        end
      end
      ARMED: begin
        if (!start) begin
          state_next = IDLE;
        end else if (strobe_ev) begin
          if (skip) skip_clr = 1'b1;
          else      capture  = 1'b1;
          fin_set    = ctrl_done;
          state_next = COLLECT;
        end else if (ctrl_done) begin
          set_short  = 1'b1;
          state_next = DONE;
        end
      end
      COLLECT: begin
        if (!start) begin
          state_next = IDLE;
        end else if (strobe_ev) begin
          capture = 1'b1;
          fin_set = ctrl_done;
        end else if (wr_en) begin
          if (cnt_inc == N_CNT) begin
            state_next = DONE;
          end else if (end_req) begin
            set_short  = 1'b1;
            state_next = DONE;
          end
        end else if (end_req) begin
          set_short  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        set_ovf = strobe_ev;
        if (!start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wire_q       <= 1'b0;
      skip         <= 1'b0;
      fin_pend     <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      result_count <= '0;
      short_err    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state  <= state_next;
      wire_q <= wire_out;
      wr_en  <= capture;
      if (capture) begin
        wr_addr <= result_count[ADDR_W-1:0];
        wr_data <= mac_in;
      end

      if (fin_set)                   fin_pend <= 1'b1;
      else if (state_next != COLLECT) fin_pend <= 1'b0;

      if (arm) begin
        result_count <= '0;
        short_err    <= 1'b0;
        overflow     <= 1'b0;
        skip         <= (SKIP_FIRST != 0);
      end else begin
        // The count advances while the write is on the bus, so wr_addr matches it.
        if (wr_en && result_count != N_CNT) result_count <= cnt_inc;
        if (set_short) short_err <= 1'b1;
        if (set_ovf)   overflow  <= 1'b1;
        if (skip_clr)  skip      <= 1'b0;
      end
    end
  end

endmodule
